// File: rtl/jtcop_trackball4701.sv
// uPD4701-style two-axis counter driven by digital inc/dec requests.
// Counts advance once every LINEDIV horizontal-blank falling edges.
// Reads take a snapshot on cs rising and return it one byte at a time.
module jtcop_trackball4701 #(
    parameter int CW      = 12,
    parameter int LINEDIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       LHBL,
    input  logic [1:0] inc,
    input  logic [1:0] dec,
    input  logic [2:0] btn,
    input  logic       x_rst,
    input  logic       y_rst,
    input  logic       cs,
    input  logic       xn_y,
    input  logic       uln,
    output logic       cfn,
    output logic       sfn,
    output logic [7:0] dout
);

    localparam int            PW    = (LINEDIV > 1) ? $clog2(LINEDIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(LINEDIV - 1);

    logic          r_lhbl_l;
    logic [PW-1:0] r_pre;
    logic [CW-1:0] r_cntx;
    logic [CW-1:0] r_cnty;
    logic [CW-1:0] r_snapx;
    logic [CW-1:0] r_snapy;
    logic          r_cs_l;
    logic          r_cfn;
    logic          r_sfn;
    logic [7:0]    r_dout;

    logic          w_tick;
    logic          w_step;
    logic          w_upx;
    logic          w_dnx;
    logic          w_upy;
    logic          w_dny;
    logic          w_chg;
    logic          w_cs_rise;
    logic          w_cs_fall;
    logic [CW-1:0] w_snap;
    logic [7:0]    w_byte;

    assign w_tick    = r_lhbl_l & ~LHBL;
    assign w_step    = w_tick & (r_pre == PLAST);

    assign w_upx     = w_step &  inc[0] & ~dec[0];
    assign w_dnx     = w_step &  dec[0] & ~inc[0];
    assign w_upy     = w_step &  inc[1] & ~dec[1];
    assign w_dny     = w_step &  dec[1] & ~inc[1];

    // a step overridden by its axis clear does not count as a change
    assign w_chg     = ((w_upx | w_dnx) & ~x_rst) | ((w_upy | w_dny) & ~y_rst);

    assign w_cs_rise = cs & ~r_cs_l;
    assign w_cs_fall = ~cs & r_cs_l;

    assign w_snap    = xn_y ? r_snapy : r_snapx;
    assign w_byte    = uln ? {{(16-CW){1'b0}}, w_snap[CW-1:8]} : w_snap[7:0];

    assign cfn       = r_cfn;
    assign sfn       = r_sfn;
    assign dout      = r_dout;

    // line tick detection and step prescaler
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lhbl_l <= 1'b1;
            r_pre    <= '0;
        end else begin
            r_lhbl_l <= LHBL;
            if (w_tick) r_pre <= (r_pre == PLAST) ? '0 : r_pre + PW'(1);
        end
    end

    // X axis counter, clear strobe wins over a step
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_cntx <= '0;
        else if (x_rst) r_cntx <= '0;
        else if (w_upx) r_cntx <= r_cntx + CW'(1);
        else if (w_dnx) r_cntx <= r_cntx - CW'(1);
    end

    // Y axis counter, clear strobe wins over a step
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_cnty <= '0;
        else if (y_rst) r_cnty <= '0;
        else if (w_upy) r_cnty <= r_cnty + CW'(1);
        else if (w_dny) r_cnty <= r_cnty - CW'(1);
    end

    // snapshot on cs rise (pre-step values) and registered byte readout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_l  <= 1'b0;
            r_snapx <= '0;
            r_snapy <= '0;
            r_dout  <= '0;
        end else begin
            r_cs_l <= cs;
            if (w_cs_rise) begin
                r_snapx <= r_cntx;
                r_snapy <= r_cnty;
            end
            if (cs) r_dout <= w_byte;
        end
    end

    // counter-changed flag and switch flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfn <= 1'b1;
            r_sfn <= 1'b1;
        end else begin
            if (w_chg)          r_cfn <= 1'b0;
            else if (w_cs_fall) r_cfn <= 1'b1;
            r_sfn <= ~|btn;
        end
    end

endmodule

// File: tb/tb_jtcop_trackball4701.sv
// Testbench for jtcop_trackball4701: directed scenarios plus randomized
// stimulus, every cycle compared against an integer reference model.
module tb_jtcop_trackball4701;

    localparam int CW   = 12;
    localparam int LD   = 4;
    localparam int MASK = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       LHBL;
    logic [1:0] inc;
    logic [1:0] dec;
    logic [2:0] btn;
    logic       x_rst;
    logic       y_rst;
    logic       cs;
    logic       xn_y;
    logic       uln;
    logic       cfn;
    logic       sfn;
    logic [7:0] dout;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int m_lines, m_cx, m_cy, m_sx, m_sy, m_dout;
    bit m_csl, m_lhbl_l, m_cfn, m_sfn;

    int lo, hi;

    always #5 clk = ~clk;

    jtcop_trackball4701 #(.CW(CW), .LINEDIV(LD)) dut (
        .clk   (clk),
        .rst   (rst),
        .LHBL  (LHBL),
        .inc   (inc),
        .dec   (dec),
        .btn   (btn),
        .x_rst (x_rst),
        .y_rst (y_rst),
        .cs    (cs),
        .xn_y  (xn_y),
        .uln   (uln),
        .cfn   (cfn),
        .sfn   (sfn),
        .dout  (dout)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_lines  = 0;
        m_cx     = 0;
        m_cy     = 0;
        m_sx     = 0;
        m_sy     = 0;
        m_dout   = 0;
        m_csl    = 1'b0;
        m_lhbl_l = 1'b1;
        m_cfn    = 1'b1;
        m_sfn    = 1'b1;
    endtask

    // advance model by one clock using the current inputs, then compare
    task automatic cyc();
        bit step, chg, rise, cfall;
        int dx, dy, s, nd;
        if (rst) begin
            m_reset();
        end else begin
            step = 1'b0;
            if (m_lhbl_l && !LHBL) begin
                m_lines++;
                step = (m_lines % LD) == 0;
            end
            dx = 0;
            dy = 0;
            if (step) begin
                if (inc[0] && !dec[0]) dx = 1;
                if (dec[0] && !inc[0]) dx = -1;
                if (inc[1] && !dec[1]) dy = 1;
                if (dec[1] && !inc[1]) dy = -1;
            end
            chg   = (dx != 0 && !x_rst) || (dy != 0 && !y_rst);
            rise  = cs && !m_csl;
            cfall = !cs && m_csl;
            nd    = m_dout;
            if (cs) begin
                s  = xn_y ? m_sy : m_sx;
                nd = uln ? (s >> 8) : (s % 256);
            end
            if (rise) begin
                m_sx = m_cx;
                m_sy = m_cy;
            end
            m_cx   = x_rst ? 0 : ((m_cx + dx) & MASK);
            m_cy   = y_rst ? 0 : ((m_cy + dy) & MASK);
            m_dout = nd;
            if (chg)        m_cfn = 1'b0;
            else if (cfall) m_cfn = 1'b1;
            m_sfn    = (btn == 3'b000);
            m_csl    = cs;
            m_lhbl_l = LHBL;
        end
        @(posedge clk);
        #1;
        chk("dout", int'(dout), m_dout);
        chk("cfn",  int'(cfn),  int'(m_cfn));
        chk("sfn",  int'(sfn),  int'(m_sfn));
        @(negedge clk);
    endtask

    task automatic lines(input int n);
        for (int i = 0; i < n; i++) begin
            LHBL = 1'b1;
            cyc();
            LHBL = 1'b0;
            cyc();
        end
    endtask

    // one cs pulse reading low then high byte of the selected axis
    task automatic read_pair(input bit axis, output int rlo, output int rhi);
        cs   = 1'b1;
        xn_y = axis;
        uln  = 1'b0;
        cyc();
        cyc();
        rlo  = int'(dout);
        uln  = 1'b1;
        cyc();
        rhi  = int'(dout);
        cs   = 1'b0;
        cyc();
    endtask

    // asynchronous reset pulse between clock edges
    task automatic arst();
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        chk("arst_dout", int'(dout), 0);
        chk("arst_cfn",  int'(cfn),  1);
        chk("arst_sfn",  int'(sfn),  1);
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; LHBL = 1'b1; inc = '0; dec = '0; btn = '0;
        x_rst = 1'b0; y_rst = 1'b0; cs = 1'b0; xn_y = 1'b0; uln = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        chk("reset_dout", int'(dout), 0);
        chk("reset_cfn",  int'(cfn),  1);
        chk("reset_sfn",  int'(sfn),  1);
        rst = 1'b0;

        // 1: two X steps, read back, flag clears on cs fall
        inc = 2'b01;
        lines(4);
        chk("t1_cfn_first_step", int'(cfn), 0);
        lines(4);
        inc = 2'b00;
        read_pair(1'b0, lo, hi);
        chk("t1_x_lo", lo, 8'h02);
        chk("t1_x_hi", hi, 8'h00);
        chk("t1_cfn_after_read", int'(cfn), 1);

        // 2: Y wraps below zero and back
        arst();
        dec = 2'b10;
        lines(4);
        dec = 2'b00;
        read_pair(1'b1, lo, hi);
        chk("t2_y_lo_wrap", lo, 8'hFF);
        chk("t2_y_hi_wrap", hi, 8'h0F);
        inc = 2'b10;
        lines(4);
        inc = 2'b00;
        read_pair(1'b1, lo, hi);
        chk("t2_y_lo_back", lo, 8'h00);
        chk("t2_y_hi_back", hi, 8'h00);

        // 3: inc and dec together hold the count
        arst();
        inc = 2'b01; dec = 2'b01;
        lines(16);
        chk("t3_cfn_hold", int'(cfn), 1);
        inc = 2'b00; dec = 2'b00;
        read_pair(1'b0, lo, hi);
        chk("t3_x_lo", lo, 0);

        // 4: clear strobe on a step tick beats the step
        arst();
        inc = 2'b01;
        lines(20);
        lines(3);
        LHBL = 1'b1;
        cyc();
        LHBL = 1'b0; x_rst = 1'b1;
        cyc();
        x_rst = 1'b0; inc = 2'b00;
        read_pair(1'b0, lo, hi);
        chk("t4_x_lo", lo, 0);
        chk("t4_x_hi", hi, 0);

        // 5: step landing during a read does not disturb the snapshot
        arst();
        inc = 2'b01;
        lines(28);
        lines(3);
        LHBL = 1'b1;
        cyc();
        cs = 1'b1; xn_y = 1'b0; uln = 1'b0;
        cyc();
        LHBL = 1'b0;
        cyc();
        chk("t5_dout_during", int'(dout), 7);
        cyc();
        chk("t5_dout_still", int'(dout), 7);
        chk("t5_cfn_in_read", int'(cfn), 0);
        cs = 1'b0; inc = 2'b00;
        cyc();
        read_pair(1'b0, lo, hi);
        chk("t5_next_read", lo, 8);

        // 6: switch flag, then async reset in the middle of a read
        btn = 3'b010;
        cyc();
        chk("t6_sfn_low", int'(sfn), 0);
        btn = 3'b000;
        cyc();
        chk("t6_sfn_high", int'(sfn), 1);
        cs = 1'b1; xn_y = 1'b0; uln = 1'b0;
        cyc();
        cyc();
        chk("t6_dout_pre", int'(dout), 8);
        arst();
        cs = 1'b0;
        cyc();
        read_pair(1'b0, lo, hi);
        chk("t6_x_after_rst", lo, 0);
        read_pair(1'b1, lo, hi);
        chk("t6_y_after_rst", lo, 0);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            LHBL  = 1'($urandom_range(0, 1));
            inc   = 2'($urandom_range(0, 3));
            dec   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            btn   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            x_rst = ($urandom_range(0, 63) == 0);
            y_rst = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 5) == 0) cs = ~cs;
            xn_y  = 1'($urandom_range(0, 1));
            uln   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 999) == 0) arst();
            else                             cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
